// File: rtl/cpu_pkg.sv
// Shared CPU types for the write-back path.
// Register-file word/address types and load-queue entry.
package cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  localparam int LQ_DEPTH_DEF = 4;

  typedef struct packed {
    reg_addr_t rd;
    word_t     data;
  } wb_ent_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LQ
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Load-result queue for the write-back arbiter.
// Same-cycle push and pop leaves the count unchanged.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  wb_ent_t       din,
  output wb_ent_t       dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_ent_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage array, written at the tail on push.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // Pointers and occupancy; pointers wrap as DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results vs. queued load results.
// Optional pending scoreboard enabled by WB_SCOREBOARD_EN.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  reg_addr_t   alu_rd,
  input  word_t       alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  reg_addr_t   ld_rd,
  input  word_t       ld_data,
  input  logic        issue_ld,
  input  reg_addr_t   issue_rd,
  output logic        stall,
  output logic [31:0] pending,
  output reg_addr_t   wr_addr,
  output word_t       wr_data,
  output logic        write_en
);

  localparam int AW = $clog2(LQ_DEPTH);

  wb_ent_t     w_head;
  wb_ent_t     w_din;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  logic        w_push;
  logic        w_pop;
  wb_src_e     w_src;
  reg_addr_t   w_sel_rd;
  word_t       w_sel_data;

  reg_addr_t   r_wr_addr;
  word_t       r_wr_data;
  logic        r_write_en;

  assign ld_ready = ~w_full;
  assign stall    = w_full;
  assign w_push   = ld_valid & ~w_full;
  assign w_din    = '{rd: ld_rd, data: ld_data};
  assign w_pop    = (w_src == SRC_LQ);

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .rst   (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Source priority: full queue, then ALU, then any queued load.
  always_comb begin
    w_src      = SRC_NONE;
    w_sel_rd   = '0;
    w_sel_data = '0;
    priority case (1'b1)
      w_full: begin
        w_src      = SRC_LQ;
        w_sel_rd   = w_head.rd;
        w_sel_data = w_head.data;
      end
      alu_valid: begin
        w_src      = SRC_ALU;
        w_sel_rd   = alu_rd;
        w_sel_data = alu_data;
      end
      !w_empty: begin
        w_src      = SRC_LQ;
        w_sel_rd   = w_head.rd;
        w_sel_data = w_head.data;
      end
      default: w_src = SRC_NONE;
    endcase
  end

  // Register the chosen result; x0 writes are consumed but suppressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_en <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else if (w_src != SRC_NONE && w_sel_rd != '0) begin
      r_write_en <= 1'b1;
      r_wr_addr  <= w_sel_rd;
      r_wr_data  <= w_sel_data;
    end else begin
      r_write_en <= 1'b0;
    end
  end

  assign write_en = r_write_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] r_pending;
  logic [31:0] w_pend_nxt;

  // Clear on queue write-back, then set on issue so a set wins.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_pop)    w_pend_nxt[w_head.rd] = 1'b0;
    if (issue_ld) w_pend_nxt[issue_rd]  = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_pend_nxt;
  end

  assign pending = r_pending;
`else
  logic w_unused;
  assign w_unused = ^{issue_ld, issue_rd, w_count};
  assign pending  = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter.
// Pending expectations follow WB_SCOREBOARD_EN.
module tb_wb_arbiter;
  import cpu_pkg::*;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  reg_addr_t   alu_rd;
  word_t       alu_data;
  logic        ld_valid;
  logic        ld_ready;
  reg_addr_t   ld_rd;
  word_t       ld_data;
  logic        issue_ld;
  reg_addr_t   issue_rd;
  logic        stall;
  logic [31:0] pending;
  reg_addr_t   wr_addr;
  word_t       wr_data;
  logic        write_en;

  int n_vec = 0;
  int n_err = 0;

  wb_arbiter #(.LQ_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .issue_ld  (issue_ld),
    .issue_rd  (issue_rd),
    .stall     (stall),
    .pending   (pending),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .write_en  (write_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    issue_ld = 0; issue_rd = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    step();
    step();
    chk("rst_we", 32'(write_en), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", wr_data, 0);
    chk("rst_rdy", 32'(ld_ready), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_pend", pending, 0);
    reset = 0;

    // Single ALU write-back
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    chk("alu_we", 32'(write_en), 1);
    chk("alu_addr", 32'(wr_addr), 5);
    chk("alu_data", wr_data, 32'hDEADBEEF);
    idle();
    step();
    chk("idle_we", 32'(write_en), 0);
    chk("idle_addr", 32'(wr_addr), 5);
    chk("idle_data", wr_data, 32'hDEADBEEF);

    // Fill queue under continuous ALU traffic
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 1; alu_data = 32'h100 + i;
      ld_valid = 1; ld_rd = reg_addr_t'(10 + i); ld_data = 32'hA0 + i;
      step();
      chk("fill_data", wr_data, 32'h100 + i);
    end
    chk("full_rdy", 32'(ld_ready), 0);
    chk("full_stall", 32'(stall), 1);
    ld_valid = 0;
    alu_rd = 2; alu_data = 32'h200;
    step();
    chk("stall_addr", 32'(wr_addr), 10);
    chk("stall_data", wr_data, 32'hA0);
    chk("post_stall", 32'(stall), 0);
    chk("post_rdy", 32'(ld_ready), 1);
    step();
    chk("alu2_addr", 32'(wr_addr), 2);
    chk("alu2_data", wr_data, 32'h200);
    idle();
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain_addr", 32'(wr_addr), 32'(10 + i));
      chk("drain_data", wr_data, 32'hA0 + i);
    end
    step();
    chk("empty_we", 32'(write_en), 0);
    chk("empty_addr", 32'(wr_addr), 13);

    // Scoreboard set, set-wins, clear
    issue_ld = 1; issue_rd = 7;
    ld_valid = 1; ld_rd = 7; ld_data = 32'h71;
    step();
    chk("pend_set", pending, SB ? 32'h80 : 32'h0);
    chk("pend_we0", 32'(write_en), 0);
    ld_valid = 0;
    step();
    chk("setwin_addr", 32'(wr_addr), 7);
    chk("setwin_data", wr_data, 32'h71);
    chk("pend_setwin", pending, SB ? 32'h80 : 32'h0);
    issue_ld = 0;
    ld_valid = 1; ld_rd = 7; ld_data = 32'h72;
    step();
    ld_valid = 0;
    step();
    chk("clr_data", wr_data, 32'h72);
    chk("pend_clr", pending, 0);

    // rd=0 results and issues
    idle();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1;
    step();
    chk("x0_we", 32'(write_en), 0);
    chk("x0_addr", 32'(wr_addr), 7);
    chk("x0_data", wr_data, 32'h72);
    idle();
    issue_ld = 1; issue_rd = 0;
    step();
    chk("x0_pend", pending, 0);
    idle();
    issue_ld = 1; issue_rd = 3;
    step();
    chk("r3_pend", pending, SB ? 32'h8 : 32'h0);
    idle();
    reset = 1;
    step();
    reset = 0;

    // Reset mid-operation with queued loads
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 3; alu_data = 32'h300 + i;
      ld_valid = 1; ld_rd = reg_addr_t'(20 + i); ld_data = 32'hB0 + i;
      issue_ld = (i < 2); issue_rd = (i == 0) ? 5'd5 : 5'd7;
      step();
    end
    chk("pre_pend", pending, SB ? 32'hA0 : 32'h0);
    chk("pre_we", 32'(write_en), 1);
    idle();
    reset = 1;
    #1;
    chk("mid_we", 32'(write_en), 0);
    chk("mid_addr", 32'(wr_addr), 0);
    chk("mid_data", wr_data, 0);
    chk("mid_pend", pending, 0);
    chk("mid_rdy", 32'(ld_ready), 1);
    chk("mid_stall", 32'(stall), 0);
    step();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_we", 32'(write_en), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
